// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// The default width is also used by the PWM generator, so both ends of the link agree.
package pwm_capture_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } pwm_cap_state_t;

  localparam int PWM_W_DEFAULT = 16;

endpackage

// File: rtl/pwm_capture_if.sv
// Bundles the enable and PWM input with the measurement results.
// The bus master drives en/pwm_in; the capture block drives the results.
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int W = PWM_W_DEFAULT
) ();

  logic         en;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         stuck_hi;
  logic         stuck_lo;

  modport master (
    output en,
    output pwm_in,
    input  period,
    input  high,
    input  valid,
    input  stuck_hi,
    input  stuck_lo
  );

  modport slave (
    input  en,
    input  pwm_in,
    output period,
    output high,
    output valid,
    output stuck_hi,
    output stuck_lo
  );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Multi-flop synchronizer for the async PWM pin, plus a one-cycle delayed copy
// so rising and falling edges of the synchronized level can be detected.
module pwm_capture_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_dly_q;
  logic                   s_dly_d;

  // next state of the synchronizer chain and delayed level
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_i};
    s_dly_d = sync_q[SYNC_STAGES-1];
  end

  // synchronizer and delay flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~s_dly_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time between consecutive rising edges
// of the synchronized input and flags a line that stops toggling.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int W           = PWM_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

  logic s;
  logic rise;
  logic fall;

  pwm_cap_state_t state_q;
  pwm_cap_state_t state_d;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] hcnt_q;
  logic [W-1:0] hcnt_d;

  logic [W-1:0] period_q;
  logic [W-1:0] period_d;
  logic [W-1:0] high_q;
  logic [W-1:0] high_d;
  logic         valid_q;
  logic         valid_d;
  logic         stuck_hi_q;
  logic         stuck_hi_d;
  logic         stuck_lo_q;
  logic         stuck_lo_d;

  logic capture;
  logic timeout;

  pwm_capture_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .async_i(bus.pwm_in),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a rise on the saturation cycle keeps the window open
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.en && rise) begin
          state_d = MEAS;
        end else begin
          state_d = IDLE;
        end
      end
      MEAS: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEAS;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          state_d = MEAS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: capture on a rise inside an open window, timeout on saturation
  always_comb begin
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      MEAS: begin
        if (bus.en && rise) begin
          capture = 1'b1;
        end else if (bus.en && (cnt_q == CNT_MAX)) begin
          timeout = 1'b1;
        end else begin
          capture = 1'b0;
        end
      end
      IDLE: begin
        capture = 1'b0;
      end
      default: begin
        capture = 1'b0;
      end
    endcase
  end

  // period and high-time counters, both restart at 1 on every rise
  always_comb begin
    cnt_d  = cnt_q;
    hcnt_d = hcnt_q;
    if (rise) begin
      cnt_d  = CNT_ONE;
      hcnt_d = CNT_ONE;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      if (s && !fall && (hcnt_q != CNT_MAX)) begin
        hcnt_d = hcnt_q + CNT_ONE;
      end else begin
        hcnt_d = hcnt_q;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_ZERO;
      hcnt_q <= CNT_ZERO;
    end else begin
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  // result next state; results and flags hold unless a capture or timeout occurs
  always_comb begin
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    if (capture) begin
      period_d   = cnt_q;
      high_d     = hcnt_q;
      valid_d    = 1'b1;
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end else if (timeout) begin
      period_d   = CNT_ZERO;
      high_d     = CNT_ZERO;
      stuck_hi_d = s;
      stuck_lo_d = ~s;
    end else begin
      valid_d = 1'b0;
    end
  end

  // result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q   <= CNT_ZERO;
      high_q     <= CNT_ZERO;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign bus.period   = period_q;
  assign bus.high     = high_q;
  assign bus.valid    = valid_q;
  assign bus.stuck_hi = stuck_hi_q;
  assign bus.stuck_lo = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (W=8): directed waveform segments from a table plus random
// segments, all checked every cycle against an edge-time reference model.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXC = 255;

  typedef struct {
    int per;
    int hi;
    int reps;
    bit en;
    int exp_per;
    int exp_hi;
    bit exp_shi;
    bit exp_slo;
  } seg_t;

  logic clk;
  logic rst;

  pwm_capture_if #(.W(W)) bus ();

  pwm_capture #(
    .W          (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state: pin samples since reset, indexed by clock edge
  bit hist[$];
  bit m_open;
  int m_last;
  int m_period;
  int m_high;
  bit m_valid;
  bit m_shi;
  bit m_slo;

  int vectors;
  int miscompares;
  int valid_cnt;
  int cyc;

  function automatic bit xs(int i);
    if (i < 0 || i >= hist.size()) return 1'b0;
    return hist[i];
  endfunction

  // A rise sampled at edge e is reported after edge e+S; the window measures
  // the distance between consecutive rises and the high samples inside it.
  task automatic model_step(input bit en_v);
    int e;
    int sum;
    bit r;
    e = hist.size() - 1 - S;
    r = xs(e) & ~xs(e - 1);
    m_valid = 1'b0;
    if (!en_v) begin
      m_open = 1'b0;
    end else if (r) begin
      if (m_open) begin
        sum = 0;
        for (int i = m_last; i < e; i++) sum += int'(xs(i));
        m_period = e - m_last;
        m_high   = sum;
        m_valid  = 1'b1;
        m_shi    = 1'b0;
        m_slo    = 1'b0;
      end
      m_open = 1'b1;
      m_last = e;
    end else if (m_open && (e - m_last == MAXC)) begin
      m_shi    = xs(e);
      m_slo    = !xs(e);
      m_period = 0;
      m_high   = 0;
      m_open   = 1'b0;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_open   = 1'b0;
    m_last   = 0;
    m_period = 0;
    m_high   = 0;
    m_valid  = 1'b0;
    m_shi    = 1'b0;
    m_slo    = 1'b0;
  endtask

  task automatic check(input string name, input logic [W-1:0] per_e, input logic [W-1:0] hi_e,
                       input logic val_e, input logic shi_e, input logic slo_e);
    vectors++;
    if ({bus.period, bus.high, bus.valid, bus.stuck_hi, bus.stuck_lo} !==
        {per_e, hi_e, val_e, shi_e, slo_e}) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got per=%0d hi=%0d v=%b shi=%b slo=%b want per=%0d hi=%0d v=%b shi=%b slo=%b",
               name, cyc, bus.period, bus.high, bus.valid, bus.stuck_hi, bus.stuck_lo,
               per_e, hi_e, val_e, shi_e, slo_e);
    end
  endtask

  task automatic tick();
    bit en_now;
    @(posedge clk);
    hist.push_back(bus.pwm_in);
    en_now = bus.en;
    #1;
    cyc++;
    model_step(en_now);
    check("model", W'(m_period), W'(m_high), m_valid, m_shi, m_slo);
    if (bus.valid === 1'b1) valid_cnt++;
  endtask

  task automatic run_wave(input int per, input int hi, input int reps, input bit en_v);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < per; c++) begin
        bus.pwm_in = (c < hi);
        bus.en     = en_v;
        tick();
      end
    end
  endtask

  seg_t segs[10];

  initial begin
    vectors     = 0;
    miscompares = 0;
    valid_cnt   = 0;
    cyc         = 0;
    model_reset();

    segs[0] = '{10,   3, 4, 1'b1, 10,   3, 1'b0, 1'b0};
    segs[1] = '{6,    5, 5, 1'b1, 6,    5, 1'b0, 1'b0};
    segs[2] = '{10,   3, 2, 1'b0, 6,    5, 1'b0, 1'b0};
    segs[3] = '{10,   3, 3, 1'b1, 10,   3, 1'b0, 1'b0};
    segs[4] = '{300,  0, 1, 1'b1, 0,    0, 1'b0, 1'b1};
    segs[5] = '{7,    2, 3, 1'b1, 7,    2, 1'b0, 1'b0};
    segs[6] = '{301, 300, 1, 1'b1, 0,   0, 1'b1, 1'b0};
    segs[7] = '{9,    4, 3, 1'b1, 9,    4, 1'b0, 1'b0};
    segs[8] = '{255, 100, 3, 1'b1, 255, 100, 1'b0, 1'b0};
    segs[9] = '{256,  1, 2, 1'b1, 0,    0, 1'b0, 1'b1};

    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    #22;
    check("reset_state", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_wave(segs[i].per, segs[i].hi, segs[i].reps, segs[i].en);
      check($sformatf("seg%0d_end", i), W'(segs[i].exp_per), W'(segs[i].exp_hi),
            bus.valid, segs[i].exp_shi, segs[i].exp_slo);
    end

    // async reset mid-period: outputs clear at once, then only the 2nd rise is valid
    run_wave(10, 3, 2, 1'b1);
    run_wave(4, 0, 1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    valid_cnt = 0;
    run_wave(10, 3, 3, 1'b1);
    vectors++;
    if (valid_cnt != 2) begin
      miscompares++;
      $display("FAIL reset_valid_count got %0d want 2", valid_cnt);
    end
    check("reset_recover", 8'd10, 8'd3, bus.valid, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int per;
      int hi;
      int reps;
      bit en_v;
      per = int'($urandom_range(40, 2));
      if ($urandom_range(9, 0) == 0) per = int'($urandom_range(270, 250));
      hi   = int'($urandom_range(per - 1, 1));
      reps = int'($urandom_range(4, 1));
      en_v = ($urandom_range(7, 0) != 0);
      run_wave(per, hi, reps, en_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
